mem_tx_serializer: RTL
======================

Name: mem_tx_serializer

Overview:
- Readback-path transmitter of the logic analyzer. After capture, it reads stored samples from the SRAM interface read port one word at a time.
- For each word, it emits only the enabled bytes (per the keep mask), LSB byte first, as an 8-bit AXI-stream toward the UART TXD stream.
- It is the outbound counterpart of the command path, which turns host UART bytes into commands.

Parameters:
- MDW, 32, memory word width in bits; must be a multiple of 8. KW = MDW/8.
- CW, 20, width of the sample count.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; begin readback of `count` samples
- count  input  CW  number of samples to read; sampled when start=1
- abort  input  1  one-cycle pulse; stop readback at the next byte boundary
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when readback completes or is aborted
- mem_rd  output  1  one-cycle read request to the SRAM interface
- mem_valid  input  1  read data valid
- mem_keep  input  KW  byte-enable mask for mem_data
- mem_data  input  MDW  read data word
- str_txd_tvalid  output  1  TXD stream valid
- str_txd_tdata  output  8  TXD stream byte
- str_txd_tready  input  1  TXD stream ready
- id_req  input  1  identify request pulse (used only with MEM_TX_ID_EN)

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst. All state updates on the posedge of clk.
- Reset values: state=IDLE, busy=0, done=0, mem_rd=0, str_txd_tvalid=0, str_txd_tdata=8'h00, remaining count=0, keep register=0, abort flag=0.
- Reset asserted mid-operation clears everything immediately (asynchronously), including tvalid. Any pending memory response is discarded.
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE:
  - start=1 with count!=0: latch cnt=count and go to REQ.
  - start=1 with count==0: go to DONE; done pulses on the next cycle.
  - start while busy is ignored.
- REQ: mem_rd=1 for exactly one cycle, then WAIT. Latency: start sampled on edge n gives mem_rd high for the cycle after edge n.
- WAIT:
  - On mem_valid=1, latch mem_data into a data register and mem_keep into a keep register.
  - keep != 0: go to SEND. tvalid rises on the cycle after mem_valid.
  - keep == 0: the word counts as a sample but emits no bytes. Do end-of-sample handling (below) directly.
  - mem_valid outside WAIT is ignored.
- SEND:
  - tvalid=1; tdata = data byte at the lowest set keep bit index i, i.e. data[8i+7:8i].
  - tdata and tvalid stay stable while tready=0 (AXI-stream rule; tvalid never drops without a handshake).
  - On tvalid & tready: clear keep bit i. If the remaining keep is nonzero, stay in SEND with the next byte presented on the next cycle, giving one byte per cycle under continuous tready. Otherwise do end-of-sample handling.
- End-of-sample:
  - cnt decrements by 1.
  - If the old cnt was 1, or the abort flag is set, go to DONE. Otherwise go to REQ.
- abort:
  - In IDLE: no effect.
  - In REQ or WAIT: set the abort flag. The outstanding word is still received and its bytes sent; afterwards go to DONE.
  - In SEND: set the abort flag. Remaining bytes of the current word are sent, then DONE.
  - The abort flag clears on entry to IDLE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in DONE.
- Counter: cnt is unsigned CW bits and never wraps, because zero is handled in IDLE.

Optional Feature:
- Macro: MEM_TX_ID_EN.
- Defined:
  - In IDLE, id_req=1 enters state ID and sends the four bytes 8'h31, 8'h41, 8'h4C, 8'h53 ("1ALS") with the same stream rules.
  - After the last byte, the block enters DONE and pulses done.
  - id_req and start asserted together: id_req wins and start is ignored.
- Not defined: the id_req port still exists but is ignored, and the ID state is absent.

Test Plan:
- start, count=2; words 32'h44332211 and 32'h88776655, both keep=4'hF; tready held 1 -> bytes 11 22 33 44 55 66 77 88 on consecutive cycles; mem_rd pulses twice; done pulses once.
- start, count=1; word 32'hAABBCCDD with keep=4'b1010 -> bytes CC then AA only; done pulses.
- start, count=3; second word has keep=4'h0 -> no bytes for that word; three mem_rd pulses; eight bytes total.
- tready low for 5 cycles while tvalid=1 with tdata=8'h11 -> tdata stays 8'h11 and tvalid stays 1 throughout; no byte is lost or duplicated.
- start, count=100; abort during byte 2 of word 3 -> bytes 3 and 4 of word 3 are sent, no further mem_rd, done pulses, busy falls. Separately, rst asserted during SEND -> tvalid=0 immediately and state returns to IDLE.
- start with count=0 -> done on the second cycle and no mem_rd. With MEM_TX_ID_EN defined, id_req -> bytes 31 41 4C 53 followed by done.

Source files
------------

// File: rtl/mem_tx_serializer.sv
// mem_tx_serializer: reads sample words from SRAM and streams their kept bytes LSB-first over AXI-stream.
// Optional identify response ("1ALS") is compiled in with MEM_TX_ID_EN.
module mem_tx_serializer #(
  parameter int MDW = 32,
  parameter int CW  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CW-1:0]      count,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               mem_rd,
  input  logic               mem_valid,
  input  logic [MDW/8-1:0]   mem_keep,
  input  logic [MDW-1:0]     mem_data,
  output logic               str_txd_tvalid,
  output logic [7:0]         str_txd_tdata,
  input  logic               str_txd_tready,
  input  logic               id_req
);
  localparam int KW = MDW / 8;
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE
`ifdef MEM_TX_ID_EN
    , S_ID
`endif
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] keep_q, keep_d;
  logic [MDW-1:0] data_q, data_d;
  logic          abort_q, abort_d;
  logic          eos;
`ifdef MEM_TX_ID_EN
  localparam logic [31:0] ID_BYTES = 32'h534C4131;
  logic [1:0] id_q, id_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) id_q <= '0;
    else     id_q <= id_d;
`else
  logic unused_id_req;
  assign unused_id_req = id_req;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      keep_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      keep_q  <= keep_d;
      data_q  <= data_d;
      abort_q <= abort_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    keep_d  = keep_q;
    data_d  = data_q;
    abort_d = abort_q | (abort && state_q != S_IDLE);
    eos     = 1'b0;
`ifdef MEM_TX_ID_EN
    id_d    = id_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MEM_TX_ID_EN
        if (id_req) begin
          state_d = S_ID;
          id_d    = '0;
        end else
`endif
        if (start) begin
          cnt_d   = count;
          state_d = (count == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (mem_valid) begin
        data_d  = mem_data;
        keep_d  = mem_keep;
        state_d = (mem_keep != '0) ? S_SEND : state_q;
        eos     = (mem_keep == '0);
      end
      S_SEND: if (str_txd_tready) begin
        // clearing the lowest set bit retires exactly the byte being presented
        keep_d = keep_q & (keep_q - KW'(1));
        eos    = (keep_d == '0);
      end
      S_DONE: state_d = S_IDLE;
`ifdef MEM_TX_ID_EN
      S_ID: if (str_txd_tready) begin
        id_d    = id_q + 2'd1;
        state_d = (id_q == 2'd3) ? S_DONE : S_ID;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (eos) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1) || abort_d) ? S_DONE : S_REQ;
    end
    if (state_d == S_IDLE) abort_d = 1'b0;
  end
  always_comb begin
    busy           = state_q != S_IDLE;
    done           = state_q == S_DONE;
    mem_rd         = state_q == S_REQ;
    str_txd_tvalid = state_q == S_SEND;
    str_txd_tdata  = 8'h00;
    if (state_q == S_SEND)
      for (int i = KW - 1; i >= 0; i--)
        if (keep_q[i]) str_txd_tdata = data_q[8*i +: 8];
`ifdef MEM_TX_ID_EN
    if (state_q == S_ID) begin
      str_txd_tvalid = 1'b1;
      str_txd_tdata  = ID_BYTES[{id_q, 3'b000} +: 8];
    end
`endif
  end
endmodule
